// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-add multiplier sequencer/arbiter.
package mult_pkg;

  localparam int MULT_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ADD,
    ST_SUB,
    ST_SHIFT,
    ST_DONE
  } mult_state_t;

  typedef logic req_idx_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the requester that was not served last wins.
module rr_arbiter2
  import mult_pkg::*;
(
  input  logic [1:0] req,
  input  req_idx_t   last,
  input  logic       enable,
  output logic [1:0] gnt,
  output req_idx_t   idx
);

  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    idx = req_idx_t'(gnt[1]);
  end

endmodule

// File: rtl/mult_arbiter.sv
// Counter-based sequencer for a shared signed shift-add multiplier with
// two-way round-robin access; the last multiplier bit uses subtract (two's complement).
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [1:0] Req,
  input  logic       M,
  output logic [1:0] Gnt,
  output logic       Sel,
  output logic       Clr_Ld,
  output logic       Add,
  output logic       Sub,
  output logic       Shift_En,
  output logic [1:0] Done,
  output logic       Busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  mult_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       gnt_r;
  req_idx_t         sel_r;
  req_idx_t         last;
  logic [1:0]       arb_gnt;
  req_idx_t         arb_idx;

  rr_arbiter2 u_arb (
    .req    (Req),
    .last   (last),
    .enable (state == ST_IDLE),
    .gnt    (arb_gnt),
    .idx    (arb_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      gnt_r <= 2'b00;
      sel_r <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            gnt_r <= arb_gnt;
            sel_r <= arb_idx;
          end
        end
        ST_LOAD:  cnt <= '0;
        ST_SHIFT: cnt <= cnt + CNT_W'(1);
        ST_DONE: begin
          last  <= sel_r;
          gnt_r <= 2'b00;
          sel_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (arb_gnt != 2'b00) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_CHECK;
      ST_CHECK: begin
        if (!M)                   state_nxt = ST_SHIFT;
        else if (cnt == CNT_LAST) state_nxt = ST_SUB;
        else                      state_nxt = ST_ADD;
      end
      ST_ADD:   state_nxt = ST_SHIFT;
      ST_SUB:   state_nxt = ST_SHIFT;
      ST_SHIFT: state_nxt = (cnt == CNT_LAST) ? ST_DONE : ST_CHECK;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs come only from registered state, grant and select.
  always_comb begin
    Gnt      = gnt_r;
    Sel      = sel_r;
    Clr_Ld   = (state == ST_LOAD);
    Add      = (state == ST_ADD);
    Sub      = (state == ST_SUB);
    Shift_En = (state == ST_SHIFT);
    Done     = (state == ST_DONE) ? gnt_r : 2'b00;
    Busy     = (state != ST_IDLE);
  end

endmodule

// File: tb/tb_mult_arbiter.sv
// Directed plus randomized bench for mult_arbiter with a B-register model driving M.
module tb_mult_arbiter;

  localparam int W = 8;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Req;
  logic       M;
  logic [1:0] Gnt;
  logic       Sel;
  logic       Clr_Ld;
  logic       Add;
  logic       Sub;
  logic       Shift_En;
  logic [1:0] Done;
  logic       Busy;

  mult_arbiter #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req      (Req),
    .M        (M),
    .Gnt      (Gnt),
    .Sel      (Sel),
    .Clr_Ld   (Clr_Ld),
    .Add      (Add),
    .Sub      (Sub),
    .Shift_En (Shift_En),
    .Done     (Done),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  // Datapath B register: loaded from the selected requester, shifted right each Shift_En.
  logic [W-1:0] b_op [2];
  logic [W-1:0] b_reg = '0;
  always @(posedge Clk) begin
    if (Clr_Ld)        b_reg <= b_op[Sel];
    else if (Shift_En) b_reg <= {1'b0, b_reg[W-1:1]};
  end
  assign M = b_reg[0];

  int checks = 0;
  int errors = 0;
  int last_m = 1;

  typedef struct {
    logic [9:0] vec;
    int         iter;
    bit         is_add;
  } exp_t;
  exp_t q[$];

  function automatic logic [9:0] cur_out();
    return {Gnt, Sel, Clr_Ld, Add, Sub, Shift_En, Done, Busy};
  endfunction

  function automatic logic [9:0] pk(input logic [1:0] g, input logic s, input logic clr,
                                    input logic a, input logic sb, input logic sh,
                                    input logic [1:0] d);
    return {g, s, clr, a, sb, sh, d, 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle trace of one multiply: LOAD, per bit CHECK[,ADD|SUB],SHIFT, then DONE.
  task automatic build(input int idx, input logic [W-1:0] b);
    logic [1:0] g;
    logic       s;
    g = (idx == 1) ? 2'b10 : 2'b01;
    s = (idx == 1);
    q.delete();
    q.push_back('{vec: pk(g, s, 1, 0, 0, 0, 2'b00), iter: -1, is_add: 1'b0});
    for (int i = 0; i < W; i++) begin
      q.push_back('{vec: pk(g, s, 0, 0, 0, 0, 2'b00), iter: i, is_add: 1'b0});
      if (b[i]) begin
        if (i == W - 1)
          q.push_back('{vec: pk(g, s, 0, 0, 1, 0, 2'b00), iter: i, is_add: 1'b0});
        else
          q.push_back('{vec: pk(g, s, 0, 1, 0, 0, 2'b00), iter: i, is_add: 1'b1});
      end
      q.push_back('{vec: pk(g, s, 0, 0, 0, 1, 2'b00), iter: i, is_add: 1'b0});
    end
    q.push_back('{vec: pk(g, s, 0, 0, 0, 0, g), iter: W, is_add: 1'b0});
  endtask

  // Called #1 into an IDLE cycle with Req already driven; returns #1 into the following IDLE cycle.
  task automatic run_job(input string name, input int abort_iter, input bit drop_after_load,
                         input bit scramble, input int done_req);
    int           idx;
    int           gcyc;
    logic [W-1:0] b;
    if (Req == 2'b11) idx = 1 - last_m;
    else              idx = Req[1] ? 1 : 0;
    b = b_op[idx];
    build(idx, b);
    gcyc = 0;
    for (int k = 0; k < q.size(); k++) begin
      @(posedge Clk); #1;
      chk($sformatf("%s cyc%0d", name, k), 32'(cur_out()), 32'(q[k].vec));
      if (Gnt != 2'b00) gcyc++;
      if (abort_iter >= 0 && q[k].is_add && q[k].iter == abort_iter) begin
        Req   = 2'b00;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        chk({name, " after_reset"}, 32'(cur_out()), 32'h0);
        last_m = 1;
        return;
      end
      if (k == 0 && drop_after_load) Req = 2'b00;
      if (scramble && k < q.size() - 1) Req = 2'($urandom_range(3, 0));
      if (k == q.size() - 1 && done_req >= 0) Req = 2'(done_req);
    end
    last_m = idx;
    chk({name, " gnt_len"}, 32'(gcyc), 32'(2 + 2 * W + $countones(b)));
    @(posedge Clk); #1;
    chk({name, " idle"}, 32'(cur_out()), 32'h0);
  endtask

  initial begin
    Reset   = 1'b1;
    Req     = 2'b00;
    b_op[0] = '0;
    b_op[1] = '0;
    @(posedge Clk); #1;
    chk("reset_hold", 32'(cur_out()), 32'h0);
    Req = 2'b11;
    @(posedge Clk); #1;
    chk("reset_ignores_req", 32'(cur_out()), 32'h0);
    Req   = 2'b00;
    Reset = 1'b0;
    last_m = 1;
    @(posedge Clk); #1;
    chk("idle_no_req", 32'(cur_out()), 32'h0);

    b_op[0] = 8'h00; Req = 2'b01;
    run_job("b00_r0", -1, 1'b0, 1'b0, 0);
    b_op[1] = 8'h05; Req = 2'b10;
    run_job("b05_r1", -1, 1'b0, 1'b0, 0);
    b_op[0] = 8'h80; Req = 2'b01;
    run_job("b80_r0", -1, 1'b0, 1'b0, 0);

    // Continuous contention after reset: 01, 10, 01 with one IDLE cycle between.
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    last_m = 1;
    chk("reset2", 32'(cur_out()), 32'h0);
    b_op[0] = 8'($urandom); b_op[1] = 8'($urandom);
    Req = 2'b11;
    run_job("rr_a", -1, 1'b0, 1'b0, -1);
    run_job("rr_b", -1, 1'b0, 1'b0, -1);
    run_job("rr_c", -1, 1'b0, 1'b0, 0);

    // Reset in the middle of an ADD, then a tie must go to requester 0.
    b_op[0] = 8'h08; Req = 2'b01;
    run_job("abort", 3, 1'b0, 1'b0, 0);
    b_op[0] = 8'($urandom); b_op[1] = 8'($urandom);
    Req = 2'b11;
    run_job("post_abort", -1, 1'b0, 1'b0, 0);

    b_op[0] = 8'($urandom); Req = 2'b01;
    run_job("drop", -1, 1'b1, 1'b0, 0);
    repeat (3) begin
      @(posedge Clk); #1;
      chk("drop_stays_idle", 32'(cur_out()), 32'h0);
    end

    for (int n = 0; n < 12; n++) begin
      b_op[0] = 8'($urandom);
      b_op[1] = 8'($urandom);
      Req = 2'($urandom_range(3, 1));
      run_job($sformatf("rand%0d", n), -1, 1'b0, 1'b1, int'($urandom_range(3, 0)));
    end
    Req = 2'b00;
    @(posedge Clk); #1;
    if (Busy) begin
      chk("final_idle", 32'(cur_out()), 32'(cur_out() & 10'h000));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
